tdm_pcm_rx: RTL and testbench

TDM_PCM_RX -- requirements
Module: tdm_pcm_rx

---
 rtl/mcac_pkg.sv | 24 ++
 rtl/pcm_fifo.sv | 80 ++++++++
 rtl/tdm_pcm_rx.sv | 170 +++++++++++++++++
 tb/tb_tdm_pcm_rx.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcac_pkg.sv
// mcac_pkg: shared definitions for the TDM PCM receive path.
//   PCM_W       - width of one A/u-law code word
//   NUM_CH_DEF  - default number of TDM channels per frame
//   CH_W        - channel index width for the largest supported frame (32 ch)
//   pcm_word_t  - buffered word {chan, data}; chan is zero-extended when the
//                 receiver is built with fewer channels
//   rx_state_t  - frame alignment states
package mcac_pkg;

  localparam int PCM_W      = 8;
  localparam int NUM_CH_DEF = 32;
  localparam int CH_W       = $clog2(NUM_CH_DEF);

  typedef struct packed {
    logic [CH_W-1:0]  chan;
    logic [PCM_W-1:0] data;
  } pcm_word_t;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } rx_state_t;

endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: small first-word-fall-through buffer for received PCM words.
//   clk, reset     - system clock, asynchronous active-high reset
//   i_flush        - synchronous flush to empty (wins over push/pop)
//   i_push         - write i_push_word; dropped when full unless a pop
//                    happens in the same cycle
//   i_pop          - consume the head word (ignored when empty)
//   o_head_word    - head entry, all zeros while empty
//   o_full/o_empty - occupancy flags
//   o_drop         - one-cycle flag: a push was discarded
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module pcm_fifo
  import mcac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_flush,
  input  logic      i_push,
  input  pcm_word_t i_push_word,
  input  logic      i_pop,
  output pcm_word_t o_head_word,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_drop
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  pcm_word_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_wr;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

  // A pop frees the slot the concurrent push needs, so a full FIFO can
  // still accept a word when the head is taken in the same cycle.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_wr   = i_push && !i_flush && (!o_full || w_pop);
  assign o_drop = i_push && !i_flush && o_full && !w_pop;

  // Masking with empty keeps the outputs at zero after reset or flush.
  assign o_head_word = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_pcm_rx.sv
// tdm_pcm_rx: TDM serial PCM receiver feeding an MCAC encoder.
//   clk, reset      - system clock, asynchronous active-high reset
//   rx_en           - enable; low forces HUNT and flushes the buffer
//   bit_en          - one-cycle strobe marking a serial bit slot
//   fs, sdi         - frame sync and MSB-first data, qualified by bit_en
//   pcm_valid/ready - handshake for the buffered word
//   pcm_data/chan   - PCM byte and its channel index
//   in_sync         - frame alignment held
//   frame_err       - one-cycle pulse on a misplaced frame sync
//   overflow/ovf_clr- sticky word-dropped flag and its clear
module tdm_pcm_rx
  import mcac_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_en,
  input  logic                      bit_en,
  input  logic                      fs,
  input  logic                      sdi,
  output logic                      pcm_valid,
  input  logic                      pcm_ready,
  output logic [PCM_W-1:0]          pcm_data,
  output logic [$clog2(NUM_CH)-1:0] pcm_chan,
  output logic                      in_sync,
  output logic                      frame_err,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int             CW        = $clog2(NUM_CH);
  localparam int             BW        = CW + 3;
  localparam logic [BW-1:0]  LAST_SLOT = BW'(NUM_CH * 8 - 1);
  localparam logic [BW-1:0]  ONE       = BW'(1);

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [BW-1:0] r_bit_cnt;
  logic [BW-1:0] w_bit_cnt_next;
  logic [1:0]    r_miss_cnt;
  logic [1:0]    w_miss_cnt_next;
  logic [6:0]    r_shift;
  logic [6:0]    w_shift_next;
  logic          r_push;
  logic          w_push_next;
  pcm_word_t     r_push_word;
  pcm_word_t     w_push_word_next;
  logic          r_frame_err;
  logic          w_frame_err_next;
  logic          r_overflow;

  pcm_word_t     w_head_word;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_bit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_word <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
      r_shift     <= w_shift_next;
      r_push      <= w_push_next;
      r_push_word <= w_push_word_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // r_bit_cnt is the index of the next slot; the slot carrying fs is bit 7
  // of channel 0, so alignment always restarts with the counter at 1.
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_miss_cnt_next  = r_miss_cnt;
    w_shift_next     = r_shift;
    w_push_next      = 1'b0;
    w_push_word_next = r_push_word;
    w_frame_err_next = 1'b0;
    if (!rx_en) begin
      w_state_next    = HUNT;
      w_bit_cnt_next  = '0;
      w_miss_cnt_next = '0;
      w_shift_next    = '0;
    end else if (bit_en) begin
      case (r_state)
        HUNT: begin
          if (fs) begin
            w_state_next    = SYNC;
            w_bit_cnt_next  = ONE;
            w_miss_cnt_next = '0;
            w_shift_next    = {6'b0, sdi};
          end
        end
        SYNC: begin
          if (fs && (r_bit_cnt != '0)) begin
            // Misplaced sync: the partial word is overwritten by realigning.
            w_frame_err_next = 1'b1;
            w_bit_cnt_next   = ONE;
            w_miss_cnt_next  = '0;
            w_shift_next     = {6'b0, sdi};
          end else if (!fs && (r_bit_cnt == '0) && (r_miss_cnt != '0)) begin
            // Second consecutive missing sync: the one-frame flywheel is spent.
            w_state_next    = HUNT;
            w_bit_cnt_next  = '0;
            w_miss_cnt_next = '0;
            w_shift_next    = '0;
          end else begin
            if (r_bit_cnt == '0) begin
              w_miss_cnt_next = fs ? 2'd0 : r_miss_cnt + 2'd1;
            end
            w_shift_next   = {r_shift[5:0], sdi};
            w_bit_cnt_next = (r_bit_cnt == LAST_SLOT) ? '0 : r_bit_cnt + ONE;
            if (r_bit_cnt[2:0] == 3'd7) begin
              w_push_next           = 1'b1;
              w_push_word_next.chan = CH_W'(r_bit_cnt[BW-1:3]);
              w_push_word_next.data = {r_shift, sdi};
            end
          end
        end
        default: begin
          w_state_next = HUNT;
        end
      endcase
    end
  end

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (!rx_en),
    .i_push      (r_push),
    .i_push_word (r_push_word),
    .i_pop       (pcm_valid && pcm_ready),
    .o_head_word (w_head_word),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_drop      (w_drop)
  );

  // A drop in the same cycle as a clear wins so no loss goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign pcm_valid = !w_empty;
  assign pcm_data  = w_head_word.data;
  assign pcm_chan  = w_head_word.chan[CW-1:0];
  assign in_sync   = (r_state == SYNC);
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tdm_pcm_rx.sv
module tb_tdm_pcm_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b0;
  logic       bit_en = 1'b0;
  logic       fs = 1'b0;
  logic       sdi = 1'b0;
  logic       pcm_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       pcm_valid;
  logic [7:0] pcm_data;
  logic [4:0] pcm_chan;
  logic       in_sync;
  logic       frame_err;
  logic       overflow;

  int          errors = 0;
  int          checks = 0;
  int          ferr_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  fb [32];

  always #5 clk = ~clk;

  tdm_pcm_rx #(
    .NUM_CH     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .bit_en    (bit_en),
    .fs        (fs),
    .sdi       (sdi),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pcm_data  (pcm_data),
    .pcm_chan  (pcm_chan),
    .in_sync   (in_sync),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // Inputs are stable from 1ns after each rising edge, so the falling edge
  // sees exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (pcm_valid && pcm_ready) begin
      obs_q.push_back({pcm_chan, pcm_data});
      $display("word chan=%0d data=0x%02h t=%0t", pcm_chan, pcm_data, $time);
    end
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) pcm_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_slot(input logic f, input logic d);
    bit_en = 1'b1;
    fs     = f;
    sdi    = d;
    tick();
    bit_en = 1'b0;
    fs     = 1'b0;
    sdi    = 1'($urandom);
    repeat (3) tick();
  endtask

  task automatic new_frame();
    for (int c = 0; c < 32; c++) fb[c] = 8'($urandom);
  endtask

  task automatic send_frame(input bit do_fs, input int first, input int last);
    for (int s = first; s <= last; s++) begin
      send_slot(do_fs && (s == 0), fb[s / 8][7 - (s % 8)]);
    end
  endtask

  task automatic expect_chans(input int first, input int last);
    for (int c = first; c <= last; c++) exp_q.push_back({5'(c), fb[c]});
  endtask

  task automatic wait_words(input int n, input int max_cyc);
    int k = 0;
    while (obs_q.size() < n && k < max_cyc) begin
      tick();
      k++;
    end
  endtask

  task automatic restart();
    rx_en = 1'b0;
    tick();
    rx_en = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pcm_valid); end
    checks++; if (pcm_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", pcm_data); end
    checks++; if (pcm_chan !== 5'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", pcm_chan); end
    checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL reset_in_sync got %b want 0", in_sync); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    tick();
    rx_en = 1'b1;
    tick();
    checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL reset_hunt got %b want 0", in_sync); end
  endtask

  task automatic test_basic();
    restart();
    pcm_ready = 1'b1;
    new_frame();
    fb[0] = 8'hD5;
    fb[1] = 8'h2A;
    expect_chans(0, 31);
    send_frame(1'b1, 0, 6);
    bit_en = 1'b1;
    sdi    = fb[0][0];
    tick();
    bit_en = 1'b0;
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 valid got %b want 0", pcm_valid); end
    tick();
    checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2 valid got %b want 1", pcm_valid); end
    checks++; if ({pcm_chan, pcm_data} !== {5'd0, 8'hD5}) begin
      errors++; $display("FAIL basic_first_word got (%0d,%02h) want (0,d5)", pcm_chan, pcm_data);
    end
    repeat (2) tick();
    send_frame(1'b1, 8, 255);
    wait_words(32, 50);
    checks++; if (in_sync !== 1'b1) begin errors++; $display("FAIL basic_in_sync got %b want 1", in_sync); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    restart();
    pcm_ready = 1'b0;
    new_frame();
    expect_chans(0, 3);
    send_frame(1'b1, 0, 255);
    repeat (4) tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", pcm_valid); end
    checks++; if ({pcm_chan, pcm_data} !== exp_q[0]) begin
      errors++; $display("FAIL ovf_head_stable got %h want %h", {pcm_chan, pcm_data}, exp_q[0]);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    // Another word into the still-full buffer while clearing in that cycle.
    new_frame();
    send_frame(1'b1, 0, 6);
    bit_en = 1'b1;
    sdi    = fb[0][0];
    tick();
    bit_en  = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_collision got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    pcm_ready = 1'b1;
    wait_words(4, 20);
    repeat (8) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL ovf_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_realign();
    restart();
    pcm_ready = 1'b1;
    new_frame();
    expect_chans(0, 11);
    send_frame(1'b1, 0, 99);
    new_frame();
    expect_chans(0, 31);
    send_frame(1'b1, 0, 255);
    wait_words(44, 50);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL realign_ferr_pulses got %0d want 1", ferr_cnt); end
    checks++; if (in_sync !== 1'b1) begin errors++; $display("FAIL realign_in_sync got %b want 1", in_sync); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL realign_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL realign_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flywheel();
    // Frame plan: sync, missing, sync, missing, missing (lost), sync.
    bit fs_plan [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit kept    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    restart();
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      new_frame();
      if (kept[f]) expect_chans(0, 31);
      send_frame(fs_plan[f], 0, 255);
      if (f == 1) begin
        checks++; if (in_sync !== 1'b1) begin errors++; $display("FAIL fly_one_miss in_sync got %b want 1", in_sync); end
      end
      if (f == 4) begin
        checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL fly_two_miss in_sync got %b want 0", in_sync); end
      end
    end
    rand_ready = 1'b0;
    pcm_ready  = 1'b1;
    wait_words(exp_q.size(), 50);
    repeat (8) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fly_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fly_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    restart();
    pcm_ready = 1'b0;
    new_frame();
    expect_chans(0, 4);
    send_frame(1'b1, 0, 38);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_pre_ovf got %b want 0", overflow); end
    bit_en = 1'b1;
    sdi    = fb[4][0];
    tick();
    bit_en    = 1'b0;
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;
    repeat (2) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", overflow); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL b2b_one_pop got %0d want 1", obs_q.size()); end
    pcm_ready = 1'b1;
    wait_words(5, 20);
    repeat (8) tick();
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rx_en_flush();
    restart();
    pcm_ready = 1'b0;
    new_frame();
    send_frame(1'b1, 0, 39);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %b want 1", overflow); end
    rx_en = 1'b0;
    tick();
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", pcm_valid); end
    checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL flush_in_sync got %b want 0", in_sync); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got %b want 1", overflow); end
    rx_en     = 1'b1;
    pcm_ready = 1'b1;
    new_frame();
    send_frame(1'b0, 0, 15);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL flush_no_words got %0d want 0", obs_q.size()); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    restart();
    pcm_ready = 1'b0;
    new_frame();
    send_frame(1'b1, 0, 36);
    checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", pcm_valid); end
    reset = 1'b1;
    #1;
    checks++; if ({pcm_valid, pcm_data, pcm_chan, in_sync, frame_err, overflow} !== 17'd0) begin
      errors++; $display("FAIL mid_reset_outputs got v=%b d=%h c=%0d s=%b e=%b o=%b want all 0",
                         pcm_valid, pcm_data, pcm_chan, in_sync, frame_err, overflow);
    end
    repeat (3) tick();
    reset     = 1'b0;
    pcm_ready = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
    new_frame();
    send_frame(1'b0, 0, 255);
    checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL mid_no_fs_in_sync got %b want 0", in_sync); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_no_fs_words got %0d want 0", obs_q.size()); end
    new_frame();
    expect_chans(0, 31);
    send_frame(1'b1, 0, 255);
    wait_words(32, 50);
    checks++; if (obs_q.size() != 32) begin errors++; $display("FAIL mid_count got %0d want 32", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_realign();
    test_flywheel();
    test_back_to_back();
    test_rx_en_flush();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
